// File: rtl/aabb_job_scheduler_if.sv
// Bundle of the request, engine and result signals around aabb_job_scheduler.
//   req/req_type/req_id : per-requester request, shape code and object id
//   gnt                 : one-hot accept pulse back to the requesters
//   eng_start/eng_done  : start pulse to, and done level from, the three AABB engines
//   eng_aabb            : {capsule, box, sphere} six-word AABB outputs, 192 bits each
//   res_*               : valid/ready result channel; busy while a job is in flight
// master: the scheduler side.  slave: the requesters/engines/consumer side.
interface aabb_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned AABB_W = 192;

    logic [NUM_REQ-1:0]      req;
    logic [2*NUM_REQ-1:0]    req_type;
    logic [ID_W*NUM_REQ-1:0] req_id;
    logic [NUM_REQ-1:0]      gnt;
    logic [2:0]              eng_start;
    logic [2:0]              eng_done;
    logic [3*AABB_W-1:0]     eng_aabb;
    logic                    res_valid;
    logic                    res_ready;
    logic [ID_W-1:0]         res_id;
    logic [1:0]              res_type;
    logic [AABB_W-1:0]       res_aabb;
    logic                    res_err;
    logic [CNT_W-1:0]        res_cycles;
    logic                    busy;

    modport master (
        input  req, req_type, req_id, eng_done, eng_aabb, res_ready,
        output gnt, eng_start, res_valid, res_id, res_type, res_aabb, res_err, res_cycles, busy
    );

    modport slave (
        output req, req_type, req_id, eng_done, eng_aabb, res_ready,
        input  gnt, eng_start, res_valid, res_id, res_type, res_aabb, res_err, res_cycles, busy
    );
endinterface

// File: rtl/aabb_job_scheduler.sv
// Round-robin scheduler sharing one sphere, one box and one capsule AABB engine among
// NUM_REQ requesters, one job in flight. Launches the engine with a one-cycle start,
// waits for the rising edge of its done, and returns the captured AABB on a
// valid/ready result channel.
// Ports: clk, rst (asynchronous, active low), bus (aabb_job_scheduler_if.master).
// Optional feature: define AABB_SCHED_TIMEOUT_EN to abort a job whose engine has not
// finished within TIMEOUT_CYCLES WAIT cycles (result flagged with res_err).
module aabb_job_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned CNT_W   = 16
`ifdef AABB_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input logic                  clk,
    input logic                  rst,
    aabb_job_scheduler_if.master bus
);
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AABB_W = 192;
    localparam logic [1:0]  TYPE_INV = 2'd3;
`ifdef AABB_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_OUT} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [2:0]          eng_start_q, eng_start_d;
    logic [2:0]          done_q, done_d;
    logic                res_valid_q, res_valid_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic [1:0]          res_type_q, res_type_d;
    logic [AABB_W-1:0]   res_aabb_q, res_aabb_d;
    logic                res_err_q, res_err_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic                busy_q, busy_d;

    logic [1:0]          type_arr [NUM_REQ];
    logic [ID_W-1:0]     id_arr   [NUM_REQ];
    logic [AABB_W-1:0]   aabb_arr [4];
    logic [3:0]          done_rise;
    logic                found;
    logic [PTR_W-1:0]    win_idx;
    int unsigned         cand;

    // Unpack per-requester and per-engine fields; slot 3 stands for the invalid type.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            type_arr[i] = bus.req_type[i*2 +: 2];
            id_arr[i]   = bus.req_id[i*ID_W +: ID_W];
        end
        for (int unsigned k = 0; k < 3; k++) begin
            aabb_arr[k] = bus.eng_aabb[k*AABB_W +: AABB_W];
        end
        aabb_arr[3] = '0;
        done_rise   = {1'b0, bus.eng_done & ~done_q};
    end

    // Round-robin pick: first active request at or after ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.req[PTR_W'(cand)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        eng_start_d = '0;
        done_d      = bus.eng_done;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_type_d  = res_type_q;
        res_aabb_d  = res_aabb_q;
        res_err_d   = res_err_q;
        cycles_d    = cycles_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    res_id_d    = id_arr[win_idx];
                    res_type_d  = type_arr[win_idx];
                    ptr_d       = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
                    // gnt and start are registered here so they appear in LAUNCH.
                    gnt_d       = NUM_REQ'(1) << win_idx;
                    eng_start_d = 3'b001 << type_arr[win_idx];
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cycles_d = '0;
                if (res_type_q == TYPE_INV) begin
                    res_err_d   = 1'b1;
                    res_aabb_d  = '0;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    res_err_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Only a fresh edge on the selected engine completes the job.
                if (done_rise[res_type_q]) begin
                    res_aabb_d  = aabb_arr[res_type_q];
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
`ifdef AABB_SCHED_TIMEOUT_EN
                else if (cycles_q == TO_LAST) begin
                    res_aabb_d  = '0;
                    res_err_d   = 1'b1;
                    cycles_d    = TO_VAL;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
`endif
                else if (cycles_q != {CNT_W{1'b1}}) begin
                    cycles_d = cycles_q + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            eng_start_q <= '0;
            done_q      <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_type_q  <= '0;
            res_aabb_q  <= '0;
            res_err_q   <= 1'b0;
            cycles_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            eng_start_q <= eng_start_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_type_q  <= res_type_d;
            res_aabb_q  <= res_aabb_d;
            res_err_q   <= res_err_d;
            cycles_q    <= cycles_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_type   = res_type_q;
    assign bus.res_aabb   = res_aabb_q;
    assign bus.res_err    = res_err_q;
    assign bus.res_cycles = cycles_q;
    assign bus.busy       = busy_q;
endmodule
